multdiv_scheduler: RTL and testbench
====================================

# multdiv_scheduler

Issue/commit controller for the shared multi-cycle multiply/divide unit in the 5-stage pipeline. Accepts a mul/div from the DX stage and launches it with a one-cycle control pulse. Tracks completion with a watchdog counter, holds the result until the regfile write port is free, then commits it. Drives the pipeline stall for structural and register-dependency hazards against the pending operation.

## Interface
- TIMEOUT, 40: BUSY cycles allowed before a missing ready is treated as an exception.
- RSTATUS, 30: register written on exception.
- clock  in  1  master clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- issue_valid  in  1  DX holds a mul or div instruction.
- issue_is_div  in  1  1 = div, 0 = mul; sampled with issue_valid.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_a, issue_b  in  32  bypassed operands from the DX operand muxes.
- dx_rs1, dx_rs2, dx_rd  in  5  source/destination registers of the instruction in DX (0 = unused).
- md_ctrl_mult, md_ctrl_div  out  1  start pulses to the multdiv unit.
- md_op_a, md_op_b  out  32  latched operands to the multdiv unit.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv overflow / divide-by-zero.
- md_ready  in  1  multdiv result valid.
- mw_write_busy  in  1  MW stage uses the regfile write port this cycle.
- stall  out  1  freeze PC/FD/DX, inject nop into XM (combinational).
- wb_valid  out  1  commit request to the regfile write mux.
- wb_reg  out  5, wb_data  out  32  commit register and data.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, LAUNCH, BUSY, HOLD.
- IDLE: when issue_valid, latch issue_a/b into md_op_a/b, latch issue_rd and issue_is_div, then go to LAUNCH. issue_valid is never stalled in IDLE.
- LAUNCH (exactly 1 cycle): md_ctrl_mult = !is_div, md_ctrl_div = is_div. Clear counter to 0. Go to BUSY. md_ready is ignored in LAUNCH.
- BUSY: the counter increments each cycle.
  - On md_ready, capture the result. If md_exception, capture reg = RSTATUS and data = 4 for mul or 5 for div. Otherwise capture reg = latched rd and data = md_result.
  - If the counter reaches TIMEOUT without md_ready, capture as an exception (same values as above).
  - After capture, go to HOLD. If the captured reg = 0, go directly to IDLE and write nothing.
- HOLD: wb_valid = !mw_write_busy. When wb_valid is high, commit this cycle and go to IDLE the next edge. Otherwise remain in HOLD; MW always has priority.
- stall = (issue_valid & state != IDLE) | (state != IDLE & pend_rd != 0 & (dx_rs1 == pend_rd | dx_rs2 == pend_rd | dx_rd == pend_rd)).
  - pend_rd is the latched rd.
  - In HOLD with an exception pending, pend_rd is RSTATUS.
- md_op_a/b stay stable from LAUNCH until return to IDLE.
- The counter is 6 bits and saturates at TIMEOUT; it never wraps.
- Reset mid-operation: abandon the pending operation with no commit. Late md_ready after reset is ignored because the block is in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, latched registers 0.
- Issue accepted at edge k → LAUNCH during cycle k+1 (pulse width exactly 1) → BUSY from k+2.
- Ready seen in BUSY at cycle n → HOLD in n+1 → earliest commit in n+1 → IDLE in n+2.
- Minimum issue-to-commit latency is 3 cycles after acceptance plus the multdiv latency.
- stall, wb_valid, wb_reg and wb_data are combinational from the state and registered latches; no input-to-output path except through stall and wb_valid.
- Back-to-back mul/div: the second instruction stalls in DX until the cycle the block is IDLE, then is accepted that cycle.
- The simultaneous event "HOLD commit and DX dependent" resolves as follows:
  - stall stays high during the commit cycle.
  - The dependent instruction proceeds the next cycle and reads the committed value via the regfile write-before-read.

## Test plan
- Mul 7×6 → r5, multdiv ready 4 cycles after pulse, mw_write_busy=0 → md_ctrl_mult high exactly 1 cycle; wb_valid with wb_reg=5, wb_data=42; busy drops the next cycle.
- Div 10/0 with md_exception=1 → wb_reg=30, wb_data=5; no write to the original rd.
- Dependent add reading r5 in DX while mul → r5 is pending → stall high throughout LAUNCH/BUSY/HOLD and drops the cycle after commit; independent add (r1, r2) → stall low.
- mw_write_busy held high 3 cycles during HOLD → wb_valid low for 3 cycles, then high for 1; result unchanged.
- md_ready never asserted → exception commit (r30 = 4 for mul) after TIMEOUT=40 BUSY cycles.
- Reset asserted in BUSY, then md_ready pulses → no wb_valid; all outputs 0; a fresh mul issued afterwards completes normally.

Source files
------------

// File: rtl/multdiv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_scheduler
// Brief    : Issue/commit controller for the shared multi-cycle mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_scheduler #(
    parameter int         TIMEOUT = 40,
    parameter logic [4:0] RSTATUS = 5'd30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  dx_rs1,
    input  logic [4:0]  dx_rs2,
    input  logic [4:0]  dx_rd,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    input  logic        mw_write_busy,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LAUNCH  = 2'd1;
    localparam logic [1:0] c_BUSY    = 2'd2;
    localparam logic [1:0] c_HOLD    = 2'd3;
    localparam logic [5:0] c_TIMEOUT = 6'(TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  w_stateNext;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [4:0]  r_rd;
    logic        r_isDiv;
    logic [5:0]  r_cnt;
    logic [4:0]  r_wbReg;
    logic [31:0] r_wbData;

    logic [5:0]  w_cntNext;
    logic        w_capture;
    logic        w_capExc;
    logic [4:0]  w_capReg;
    logic [31:0] w_capData;
    logic [4:0]  w_pendRd;

    // Counter saturates so a stuck unit can never wrap back below the limit.
    assign w_cntNext = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + 6'd1;

    always_comb begin
        w_capture = 1'b0;
        w_capExc  = 1'b0;
        w_capReg  = r_rd;
        w_capData = md_result;
        if (r_state == c_BUSY) begin
            w_capture = md_ready | (w_cntNext == c_TIMEOUT);
            w_capExc  = md_ready ? md_exception : 1'b1;
        end
        if (w_capExc) begin
            w_capReg  = RSTATUS;
            w_capData = r_isDiv ? 32'd5 : 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE:   if (issue_valid) w_stateNext = c_LAUNCH;
            c_LAUNCH: w_stateNext = c_BUSY;
            c_BUSY: begin
                if (w_capture) w_stateNext = (w_capReg == 5'd0) ? c_IDLE : c_HOLD;
            end
            c_HOLD:   if (!mw_write_busy) w_stateNext = c_IDLE;
            default:  w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_opA    <= 32'd0;
            r_opB    <= 32'd0;
            r_rd     <= 5'd0;
            r_isDiv  <= 1'b0;
            r_cnt    <= 6'd0;
            r_wbReg  <= 5'd0;
            r_wbData <= 32'd0;
        end else begin
            if (r_state == c_IDLE && issue_valid) begin
                r_opA   <= issue_a;
                r_opB   <= issue_b;
                r_rd    <= issue_rd;
                r_isDiv <= issue_is_div;
            end
            if (r_state == c_LAUNCH) begin
                r_cnt <= 6'd0;
            end else if (r_state == c_BUSY) begin
                r_cnt <= w_cntNext;
            end
            if (w_capture) begin
                r_wbReg  <= w_capReg;
                r_wbData <= w_capData;
            end
        end
    end

    // Once captured, the hazard register is whatever will actually be written.
    assign w_pendRd = (r_state == c_HOLD) ? r_wbReg : r_rd;

    assign busy         = (r_state != c_IDLE);
    assign md_ctrl_mult = (r_state == c_LAUNCH) & ~r_isDiv;
    assign md_ctrl_div  = (r_state == c_LAUNCH) &  r_isDiv;
    assign md_op_a      = r_opA;
    assign md_op_b      = r_opB;
    assign stall        = busy & (issue_valid |
                          ((w_pendRd != 5'd0) &
                           ((dx_rs1 == w_pendRd) | (dx_rs2 == w_pendRd) | (dx_rd == w_pendRd))));
    assign wb_valid     = (r_state == c_HOLD) & ~mw_write_busy;
    assign wb_reg       = (r_state == c_HOLD) ? r_wbReg  : 5'd0;
    assign wb_data      = (r_state == c_HOLD) ? r_wbData : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_scheduler.sv
`default_nettype none
// Scoreboard bench for multdiv_scheduler: expected commits are queued at issue
// and compared by a monitor whenever the block drives a write-back.
module tb_multdiv_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_div;
    logic [4:0]  issue_rd, dx_rs1, dx_rs2, dx_rd;
    logic [31:0] issue_a, issue_b;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_op_a, md_op_b, md_result;
    logic        md_exception, md_ready, mw_write_busy;
    logic        stall, wb_valid, busy;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [36:0] sbQ [$];
    logic [36:0] monE;

    multdiv_scheduler #(.TIMEOUT(40), .RSTATUS(5'd30)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .dx_rs1(dx_rs1), .dx_rs2(dx_rs2), .dx_rd(dx_rd),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_op_a(md_op_a), .md_op_b(md_op_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .mw_write_busy(mw_write_busy),
        .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every write-back must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (wb_valid) begin
            if (sbQ.size() == 0) begin
                checkEq("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                monE = sbQ.pop_front();
                checkEq("wb_reg", 32'(wb_reg), 32'(monE[36:32]));
                checkEq("wb_data", wb_data, monE[31:0]);
            end
        end
    end

    // lat = cycles from launch pulse to md_ready; lat == 0 means ready never comes.
    task automatic runOp(input logic isDiv, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic exc,
                         input int mwHold, input logic stallBusy, input logic stallHold);
        logic        excEff;
        logic [4:0]  expReg;
        logic [31:0] expData;
        int          n;
        excEff  = exc || (lat == 0);
        expReg  = excEff ? 5'd30 : rd;
        expData = excEff ? (isDiv ? 32'd5 : 32'd4) : (isDiv ? a / b : a * b);
        if (expReg != 5'd0) sbQ.push_back({expReg, expData});

        issue_valid = 1'b1; issue_is_div = isDiv; issue_rd = rd; issue_a = a; issue_b = b;
        #2 checkEq("stall_idle", 32'(stall), 32'd0);
        tick();
        issue_valid = 1'b0;
        #2;
        checkEq("pulse_mult", 32'(md_ctrl_mult), 32'(!isDiv));
        checkEq("pulse_div", 32'(md_ctrl_div), 32'(isDiv));
        checkEq("op_a", md_op_a, a);
        checkEq("op_b", md_op_b, b);
        checkEq("stall_launch", 32'(stall), 32'(stallBusy));
        issue_valid = 1'b1;
        #1 checkEq("stall_struct", 32'(stall), 32'd1);
        issue_valid = 1'b0;
        tick();
        #2;
        checkEq("pulse_end", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        checkEq("stall_busy", 32'(stall), 32'(stallBusy));

        if (lat > 0) begin
            repeat (lat - 1) tick();
            md_ready = 1'b1; md_exception = exc;
            md_result = exc ? 32'hDEAD_BEEF : (isDiv ? a / b : a * b);
            mw_write_busy = (mwHold > 0);
            tick();
            md_ready = 1'b0; md_exception = 1'b0;
            #2;
        end else begin
            n = 1;
            while (!wb_valid && n < 100) begin
                tick();
                n++;
                #2;
            end
            checkEq("timeout_cycles", 32'(n - 1), 32'd40);
        end

        if (expReg == 5'd0) begin
            checkEq("rd0_idle", 32'(busy), 32'd0);
            checkEq("rd0_nowb", 32'(wb_valid), 32'd0);
            return;
        end
        checkEq("stall_hold", 32'(stall), 32'(stallHold));
        for (int i = 0; i < mwHold; i++) begin
            checkEq("wb_blocked", 32'(wb_valid), 32'd0);
            checkEq("wb_data_held", wb_data, expData);
            tick();
            if (i == mwHold - 1) mw_write_busy = 1'b0;
            #2;
        end
        checkEq("wb_valid", 32'(wb_valid), 32'd1);
        checkEq("stall_commit", 32'(stall), 32'(stallHold));
        tick();
        #2;
        checkEq("busy_drop", 32'(busy), 32'd0);
        checkEq("stall_after", 32'(stall), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = 5'd0;
        issue_a = 32'd0; issue_b = 32'd0; dx_rs1 = 5'd0; dx_rs2 = 5'd0; dx_rd = 5'd0;
        md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0; mw_write_busy = 1'b0;
        tick();
        tick();
        #2;
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_stall", 32'(stall), 32'd0);
        checkEq("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkEq("rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        checkEq("rst_op_a", md_op_a, 32'd0);
        checkEq("rst_wb_reg", 32'(wb_reg), 32'd0);
        checkEq("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        tick();

        // Independent add (r1, r2) while mul 7x6 -> r5 runs.
        dx_rs1 = 5'd1; dx_rs2 = 5'd2; dx_rd = 5'd3;
        runOp(1'b0, 5'd5, 32'd7, 32'd6, 4, 1'b0, 0, 1'b0, 1'b0);
        // Dependent add reading r5.
        dx_rs1 = 5'd5;
        runOp(1'b0, 5'd5, 32'd3, 32'd9, 4, 1'b0, 0, 1'b1, 1'b1);
        // Div by zero: hazard moves from r9 to RSTATUS once captured.
        dx_rs1 = 5'd9; dx_rs2 = 5'd0; dx_rd = 5'd0;
        runOp(1'b1, 5'd9, 32'd10, 32'd0, 3, 1'b1, 0, 1'b1, 1'b0);
        // Write port held by MW for 3 cycles.
        dx_rs1 = 5'd0;
        runOp(1'b1, 5'd12, 32'd100, 32'd7, 2, 1'b0, 3, 1'b0, 1'b0);
        // md_ready never arrives: timeout exception into r30.
        dx_rd = 5'd30;
        runOp(1'b0, 5'd4, 32'd5, 32'd5, 0, 1'b0, 0, 1'b0, 1'b1);
        // Destination r0: no commit, no hazard.
        dx_rd = 5'd0;
        runOp(1'b0, 5'd0, 32'd3, 32'd3, 2, 1'b0, 0, 1'b0, 1'b0);
        tick();

        // Reset in BUSY followed by a late ready pulse.
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd7;
        issue_a = 32'd11; issue_b = 32'd13;
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        md_ready = 1'b1; md_result = 32'd143;
        tick();
        md_ready = 1'b0;
        #2;
        checkEq("rstmid_busy", 32'(busy), 32'd0);
        checkEq("rstmid_wb_valid", 32'(wb_valid), 32'd0);
        checkEq("rstmid_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        checkEq("rstmid_op_a", md_op_a, 32'd0);
        checkEq("rstmid_op_b", md_op_b, 32'd0);
        checkEq("rstmid_wb", 32'(wb_reg) | wb_data, 32'd0);
        checkEq("rstmid_stall", 32'(stall), 32'd0);
        repeat (2) tick();

        runOp(1'b0, 5'd7, 32'd11, 32'd13, 3, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checkEq("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
